// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared definitions for the vending dispense scheduler:
//                default parameters, scheduler state encoding and the
//                lane-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int VEND_N_LANES = 4;
    localparam int VEND_TIMEOUT = 200;
    localparam int VEND_GAP     = 3;

    localparam logic [2:0] VEND_ST_IDLE   = 3'd0;
    localparam logic [2:0] VEND_ST_START  = 3'd1;
    localparam logic [2:0] VEND_ST_WAIT   = 3'd2;
    localparam logic [2:0] VEND_ST_DONE   = 3'd3;
    localparam logic [2:0] VEND_ST_FAULT  = 3'd4;
    localparam logic [2:0] VEND_ST_SETTLE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = VEND_ST_IDLE,
        S_START  = VEND_ST_START,
        S_WAIT   = VEND_ST_WAIT,
        S_DONE   = VEND_ST_DONE,
        S_FAULT  = VEND_ST_FAULT,
        S_SETTLE = VEND_ST_SETTLE
    } vend_state_e;

    // Width of a lane index; never narrower than one bit.
    function automatic int vend_lane_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : vend_rr_pick
//  Description : Combinational round-robin picker. Returns the first set bit
//                of mask_i found scanning upward from ptr_i with wrap-around.
//  Ports       : mask_i  - candidate lanes
//                ptr_i   - lane to start scanning from
//                found_o - at least one candidate present
//                idx_o   - selected lane (0 when nothing found)
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_rr_pick
    import vend_pkg::*;
#(
    parameter  int N_LANES = VEND_N_LANES,
    localparam int LW      = vend_lane_w(N_LANES)
) (
    input  logic [N_LANES-1:0] mask_i,
    input  logic [LW-1:0]      ptr_i,
    output logic               found_o,
    output logic [LW-1:0]      idx_o
);

    // Scan from the farthest offset down to offset 0 so that the nearest
    // candidate is written last and wins, avoiding an early loop exit.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            logic [LW-1:0] cand;
            cand = LW'((int'(ptr_i) + i) % N_LANES);
            if (mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_dispense_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : vend_dispense_scheduler
//  Description : Shares one dispense motor between N_LANES vending lanes.
//                Grants lanes round-robin, pulses the motor start, waits for
//                completion or timeout, acknowledges or faults the lane and
//                then holds off for a GAP-cycle mechanical settle period.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                req_i            - per-lane level dispense request
//                motor_done_i     - motor driver completion pulse
//                motor_start_o    - one-cycle motor start pulse
//                lane_sel_o       - lane being served
//                busy_o           - scheduler not idle
//                dispensed_o      - one-hot acknowledge to served lane
//                fault_o          - one-cycle timeout pulse
//                lane_disabled_o  - sticky mask of faulted lanes
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_dispense_scheduler
    import vend_pkg::*;
#(
    parameter  int N_LANES = VEND_N_LANES,
    parameter  int TIMEOUT = VEND_TIMEOUT,
    parameter  int GAP     = VEND_GAP,
    localparam int LW      = vend_lane_w(N_LANES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] req_i,
    input  logic               motor_done_i,
    output logic               motor_start_o,
    output logic [LW-1:0]      lane_sel_o,
    output logic               busy_o,
    output logic [N_LANES-1:0] dispensed_o,
    output logic               fault_o,
    output logic [N_LANES-1:0] lane_disabled_o
);

    // The timer serves both the WAIT timeout and the SETTLE gap, so it is
    // sized for whichever is larger; it never counts past that bound.
    localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int TW   = $clog2(TMAX + 1);

    vend_state_e        state_q, state_d;
    logic [LW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [LW-1:0]      lane_sel_q, lane_sel_d;
    logic [N_LANES-1:0] lane_dis_q, lane_dis_d;

    logic               pick_found;
    logic [LW-1:0]      pick_idx;
    logic [LW-1:0]      next_ptr;
    logic [N_LANES-1:0] set_dis;

    vend_rr_pick #(
        .N_LANES (N_LANES)
    ) u_pick (
        .mask_i  (req_i & ~lane_dis_q),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign next_ptr = (lane_sel_q == LW'(N_LANES - 1)) ? '0 : lane_sel_q + 1'b1;

    // Per-lane decode of the served lane for the acknowledge and fault mask.
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign dispensed_o[g] = (state_q == S_DONE)  && (lane_sel_q == LW'(g));
        assign set_dis[g]     = (state_q == S_FAULT) && (lane_sel_q == LW'(g));
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        timer_d    = timer_q;
        lane_sel_d = lane_sel_q;
        lane_dis_d = lane_dis_q | set_dis;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    lane_sel_d = pick_idx;
                    state_d    = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // Completion has priority over a coincident timeout.
                if (motor_done_i) begin
                    state_d = S_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE, S_FAULT: begin
                rr_ptr_d = next_ptr;
                timer_d  = '0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_q == TW'(GAP - 1)) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            timer_q    <= '0;
            lane_sel_q <= '0;
            lane_dis_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            timer_q    <= timer_d;
            lane_sel_q <= lane_sel_d;
            lane_dis_q <= lane_dis_d;
        end
    end

    assign motor_start_o   = (state_q == S_START);
    assign busy_o          = (state_q != S_IDLE);
    assign fault_o         = (state_q == S_FAULT);
    assign lane_sel_o      = lane_sel_q;
    assign lane_disabled_o = lane_dis_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_dispense_scheduler
//  Description : Self-checking bench for vend_dispense_scheduler. A
//                transaction-offset reference model predicts every output on
//                every cycle; directed scenarios are followed by a random run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_scheduler;

    localparam int N  = 4;
    localparam int TO = 200;
    localparam int G  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       motor_done;
    logic       motor_start;
    logic [1:0] lane_sel;
    logic       busy;
    logic [3:0] dispensed;
    logic       fault;
    logic [3:0] lane_disabled;

    vend_dispense_scheduler #(
        .N_LANES (N),
        .TIMEOUT (TO),
        .GAP     (G)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_i           (req),
        .motor_done_i    (motor_done),
        .motor_start_o   (motor_start),
        .lane_sel_o      (lane_sel),
        .busy_o          (busy),
        .dispensed_o     (dispensed),
        .fault_o         (fault),
        .lane_disabled_o (lane_disabled)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. m_k is the cycle offset since the grant (0 = motor
    // start cycle, -1 = idle). m_end is the offset of the last waiting cycle
    // once known; the outcome cycle follows it, then G settle cycles.
    int         m_k;
    int         m_end;
    int         m_lane;
    int         m_ptr;
    bit         m_ok;
    bit         m_after_rst;
    logic [3:0] m_dis;
    int         m_tgt;

    task automatic model_reset();
        m_k         = -1;
        m_end       = -1;
        m_lane      = 0;
        m_ptr       = 0;
        m_ok        = 1'b0;
        m_after_rst = 1'b1;
        m_dis       = 4'b0000;
    endtask

    task automatic model_update(input logic r, input logic [3:0] rq, input logic d);
        logic [3:0] elig;
        if (r) begin
            model_reset();
        end else if (m_k < 0) begin
            elig = rq & ~m_dis;
            if (elig != 4'b0000) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (elig[(m_ptr + i) % N]) m_lane = (m_ptr + i) % N;
                end
                m_k         = 0;
                m_end       = -1;
                m_after_rst = 1'b0;
            end
        end else begin
            if (m_k >= 1 && m_end < 0) begin
                if (d) begin
                    m_end = m_k;
                    m_ok  = 1'b1;
                end else if (m_k == TO) begin
                    m_end = m_k;
                    m_ok  = 1'b0;
                end
            end else if (m_end >= 0 && m_k == m_end + 1) begin
                m_ptr = (m_lane + 1) % N;
                if (!m_ok) m_dis[m_lane] = 1'b1;
            end
            m_k++;
            if (m_end >= 0 && m_k > m_end + 1 + G) m_k = -1;
        end
    endtask

    task automatic check_outputs();
        bit outcome;
        outcome = (m_k >= 0) && (m_end >= 0) && (m_k == m_end + 1);
        check_val("motor_start", motor_start, (m_k == 0));
        check_val("busy", busy, (m_k >= 0));
        check_val("dispensed", dispensed, (outcome && m_ok) ? (32'd1 << m_lane) : 32'd0);
        check_val("fault", fault, (outcome && !m_ok));
        check_val("lane_disabled", lane_disabled, m_dis);
        if (m_k >= 0 && (m_end < 0 || m_k <= m_end))
            check_val("lane_sel", lane_sel, m_lane);
        else if (m_k < 0 && m_after_rst)
            check_val("lane_sel_rst", lane_sel, 0);
    endtask

    // One clock cycle: check the current outputs, drive the inputs that the
    // next rising edge will sample, advance the model alongside.
    task automatic step(input logic r, input logic [3:0] rq, input logic d);
        @(negedge clk);
        check_outputs();
        rst        = r;
        req        = rq;
        motor_done = d;
        model_update(r, rq, d);
        @(posedge clk);
    endtask

    function automatic bit in_wait();
        return (m_k >= 1) && (m_end < 0);
    endfunction

    function automatic bit in_settle();
        return (m_end >= 0) && (m_k > m_end + 1);
    endfunction

    logic [3:0] rq_r;
    logic       d_r;
    logic       r_r;

    initial begin
        rst        = 1'b1;
        req        = 4'b0000;
        motor_done = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Single lane 2, motor completes five cycles after start.
        step(1'b0, 4'b0000, 1'b0);
        for (int c = 0; c < 20; c++)
            step(1'b0, (m_k < 0 && m_end < 0) ? 4'b0100 : 4'b0000, in_wait() && m_k == 5);

        // All lanes requesting, motor done on the second waiting cycle.
        for (int c = 0; c < 60; c++)
            step(1'b0, 4'b1111, in_wait() && m_k == 2);

        // Lane 1 times out, then is locked out until reset.
        step(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 215; c++)
            step(1'b0, 4'b0010, 1'b0);
        check_val("dis_after_fault", lane_disabled, 4'b0010);
        for (int c = 0; c < 20; c++)
            step(1'b0, 4'b0010, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        check_val("dis_after_rst", lane_disabled, 4'b0000);

        // Completion coincides with the last permitted waiting cycle.
        for (int c = 0; c < 215; c++)
            step(1'b0, (m_k < 0 && m_end < 0) ? 4'b0001 : 4'b0000, in_wait() && m_k == TO);

        // Reset in the middle of waiting on lane 3, then a stray done.
        for (int c = 0; c < 8; c++)
            step(1'b0, 4'b1000, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Lane 0 request pulsed only during settle is never granted.
        for (int c = 0; c < 20; c++) begin
            if (m_k < 0 && m_end < 0) rq_r = 4'b0100;
            else if (in_settle())     rq_r = 4'b0001;
            else                      rq_r = 4'b0000;
            step(1'b0, rq_r, in_wait() && m_k == 1);
        end

        // Randomized run.
        rq_r = 4'b0000;
        for (int c = 0; c < 8000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 99) < 15) rq_r[b] = $urandom_range(0, 1) == 1;
            if (m_k == 0) begin
                case ($urandom_range(0, 19))
                    14:      m_tgt = TO;
                    15:      m_tgt = TO - 1;
                    16, 17:  m_tgt = TO + 10;
                    default: m_tgt = $urandom_range(1, 6);
                endcase
            end
            if (in_wait()) d_r = (m_k == m_tgt);
            else           d_r = ($urandom_range(0, 9) == 0);
            r_r = ($urandom_range(0, 999) == 0) ||
                  (m_dis == 4'b1111 && $urandom_range(0, 19) == 0);
            step(r_r, rq_r, d_r);
        end
        step(1'b0, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
